rr_mux_n_1: RTL and testbench

- Round-robin N-to-1 stream multiplexer: the gather-side counterpart of the team's 1-to-N demux.
- Merges N valid/ready input lanes into one registered output stream.
- Tags each output word with the source lane index so a downstream 1-to-N demux can route it back.
- Sits between per-lane producers and a shared single-lane consumer.

---
 rtl/rr_mux_n_1_pkg.sv | 18 +
 rtl/rr_mux_n_1_arbiter.sv | 42 ++++
 rtl/rr_mux_n_1.sv | 81 ++++++++
 tb/tb_rr_mux_n_1.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_n_1_pkg.sv
// Shared constants and helpers for the round-robin N-to-1 stream mux.
// DEF_N / DEF_WIDTH are shared with the 1-to-N demux so that the mux's
// out_sel width always matches the demux select width.
package rr_mux_n_1_pkg;

  // Ceiling log2 for elaboration-time width derivation (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_N     = 16;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEL_W = clog2(DEF_N);

endpackage

// File: rtl/rr_mux_n_1_arbiter.sv
// rr_arbiter_n: combinational round-robin grant.
// Ports:
//   req        - per-lane request vector
//   ptr        - highest-priority lane index (always < N)
//   en         - qualifies the one-hot grant; gnt_idx/any are unqualified
//   gnt_onehot - one-hot grant, zero when en=0 or no request
//   gnt_idx    - index of the first requesting lane at or after ptr (wrapping)
//   any        - at least one lane is requesting
module rr_arbiter_n
  import rr_mux_n_1_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    int idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    // Walk ptr, ptr+1, ... with an explicit wrap at N so non-power-of-two
    // lane counts never search past the last real lane.
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx[SEL_W-1:0];
      end
    end
    if (en && any) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_mux_n_1.sv
// rr_mux_n_1: round-robin N-to-1 valid/ready stream multiplexer with a
// one-entry registered output tagged by source lane index.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_data/in_valid  - N packed lanes, lane i at [i*WIDTH +: WIDTH]
//   in_ready          - per-lane accept, one-hot or zero (combinational)
//   out_data/out_sel  - registered word and its source lane
//   out_valid         - registered output valid
//   out_ready         - downstream accept
module rr_mux_n_1
  import rr_mux_n_1_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEL_W = clog2(N),
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_valid;

  logic             w_load_en;
  logic             w_any;
  logic [N-1:0]     w_gnt_onehot;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [SEL_W-1:0] w_ptr_next;
  logic [WIDTH-1:0] w_gnt_data;

  // Load whenever the output slot is empty or draining this cycle, so a
  // simultaneous drain and load leaves no bubble.
  assign w_load_en = (!r_out_valid || out_ready) && w_any;

  rr_arbiter_n #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req        (in_valid),
    .ptr        (r_ptr),
    .en         (w_load_en),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  // Reset is asynchronous, so in_ready must be masked combinationally too.
  assign in_ready   = rst ? '0 : w_gnt_onehot;
  assign w_gnt_data = in_data[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_ptr_next = (w_gnt_idx == SEL_W'(N-1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load_en) begin
      r_ptr       <= w_ptr_next;
      r_out_data  <= w_gnt_data;
      r_out_sel   <= w_gnt_idx;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_n_1.sv
module tb_rr_mux_n_1;

  logic          clk;
  logic          rst;
  logic [127:0]  in_data;
  logic [15:0]   in_valid;
  logic [15:0]   in_ready;
  logic [7:0]    out_data;
  logic [3:0]    out_sel;
  logic          out_valid;
  logic          out_ready;

  logic [39:0]   in_data5;
  logic [4:0]    in_valid5;
  logic [4:0]    in_ready5;
  logic [7:0]    out_data5;
  logic [2:0]    out_sel5;
  logic          out_valid5;
  logic          out_ready5;

  int checks;
  int failures;

  rr_mux_n_1 #(.N(16), .SEL_W(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  rr_mux_n_1 #(.N(5), .SEL_W(3), .WIDTH(8)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .out_data  (out_data5),
    .out_sel   (out_sel5),
    .out_valid (out_valid5),
    .out_ready (out_ready5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0; out_ready = 1'b0; in_data = '0;
    in_valid5 = '0; out_ready5 = 1'b0; in_data5 = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Reset held through an edge with every lane requesting.
    rst = 1'b1;
    in_valid = 16'hFFFF; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (out_sel !== 4'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", out_sel); end
    checks++; if (in_ready !== 16'h0000) begin failures++; $display("FAIL reset_in_ready got=%h exp=0000", in_ready); end

    // Reset asserted mid-stream while lane 5 word is held under backpressure.
    do_reset();
    in_valid = 16'h0020; in_data[5*8 +: 8] = 8'hA5; out_ready = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_sel !== 4'd5 || out_data !== 8'hA5) begin
      failures++; $display("FAIL midrst_load got=%0b/%0d/%h exp=1/5/a5", out_valid, out_sel, out_data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_sel !== 4'd0 || out_data !== 8'h00) begin
      failures++; $display("FAIL midrst_async got=%0b/%0d/%h exp=0/0/00", out_valid, out_sel, out_data); end
    checks++; if (in_ready !== 16'h0000) begin failures++; $display("FAIL midrst_in_ready got=%h exp=0000", in_ready); end
    in_valid = 16'h0088; in_data[3*8 +: 8] = 8'h33; in_data[7*8 +: 8] = 8'h77; out_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 16'h0008) begin failures++; $display("FAIL midrst_first_ready got=%h exp=0008", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_sel !== 4'd3 || out_data !== 8'h33) begin
      failures++; $display("FAIL midrst_first_grant got=%0b/%0d/%h exp=1/3/33", out_valid, out_sel, out_data); end
  endtask

  task automatic test_all_lanes();
    logic [3:0] exp_sel;
    do_reset();
    in_valid = 16'hFFFF; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
    #1;
    checks++; if (in_ready !== 16'h0001) begin failures++; $display("FAIL all_first_ready got=%h exp=0001", in_ready); end
    for (int k = 0; k < 18; k++) begin
      step();
      exp_sel = 4'(k % 16);
      checks++; if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== 8'(8'h10 + exp_sel)) begin
        failures++; $display("FAIL all_lanes[%0d] got=%0b/%0d/%h exp=1/%0d/%h", k, out_valid, out_sel, out_data, exp_sel, 8'(8'h10 + exp_sel)); end
    end
  endtask

  task automatic test_sparse();
    logic [15:0] exp_rdy;
    logic [3:0]  exp_sel;
    do_reset();
    in_valid = 16'h8001; out_ready = 1'b1;
    in_data[0 +: 8] = 8'hC0; in_data[15*8 +: 8] = 8'hCF;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 16'h0001 : 16'h8000;
      exp_sel = (k % 2 == 0) ? 4'd0 : 4'd15;
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL sparse_ready[%0d] got=%h exp=%h", k, in_ready, exp_rdy); end
      step();
      checks++; if (out_valid !== 1'b1 || out_sel !== exp_sel) begin
        failures++; $display("FAIL sparse_sel[%0d] got=%0b/%0d exp=1/%0d", k, out_valid, out_sel, exp_sel); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 16'h0008; in_data[3*8 +: 8] = 8'h3C; out_ready = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1 || out_sel !== 4'd3 || out_data !== 8'h3C) begin
        failures++; $display("FAIL bp_hold[%0d] got=%0b/%0d/%h exp=1/3/3c", k, out_valid, out_sel, out_data); end
      checks++; if (in_ready !== 16'h0000) begin failures++; $display("FAIL bp_ready[%0d] got=%h exp=0000", k, in_ready); end
      in_data[3*8 +: 8] = 8'h3D;
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 16'h0008) begin failures++; $display("FAIL bp_release_ready got=%h exp=0008", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_sel !== 4'd3 || out_data !== 8'h3D) begin
      failures++; $display("FAIL bp_next_word got=%0b/%0d/%h exp=1/3/3d", out_valid, out_sel, out_data); end
  endtask

  task automatic test_wrap_n5();
    do_reset();
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'(8'h50 + i);
    in_valid5 = 5'b10000; out_ready5 = 1'b1;
    step();
    checks++; if (out_valid5 !== 1'b1 || out_sel5 !== 3'd4 || out_data5 !== 8'h54) begin
      failures++; $display("FAIL wrap_first got=%0b/%0d/%h exp=1/4/54", out_valid5, out_sel5, out_data5); end
    // ptr is now 0, so lane 1 outranks lane 4.
    in_valid5 = 5'b10010;
    #1;
    checks++; if (in_ready5 !== 5'b00010) begin failures++; $display("FAIL wrap_ready1 got=%b exp=00010", in_ready5); end
    step();
    checks++; if (out_sel5 !== 3'd1 || out_data5 !== 8'h51) begin failures++; $display("FAIL wrap_grant1 got=%0d/%h exp=1/51", out_sel5, out_data5); end
    checks++; if (in_ready5 !== 5'b10000) begin failures++; $display("FAIL wrap_ready4 got=%b exp=10000", in_ready5); end
    step();
    checks++; if (out_sel5 !== 3'd4 || out_data5 !== 8'h54) begin failures++; $display("FAIL wrap_grant4 got=%0d/%h exp=4/54", out_sel5, out_data5); end
    step();
    checks++; if (out_sel5 !== 3'd1) begin failures++; $display("FAIL wrap_again got=%0d exp=1", out_sel5); end
  endtask

  task automatic test_idle_drain();
    do_reset();
    in_valid = 16'h0080; in_data[7*8 +: 8] = 8'h77; out_ready = 1'b1;
    step();
    in_valid = 16'h0000;
    checks++; if (out_valid !== 1'b1 || out_sel !== 4'd7 || out_data !== 8'h77) begin
      failures++; $display("FAIL drain_load got=%0b/%0d/%h exp=1/7/77", out_valid, out_sel, out_data); end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (out_valid !== 1'b0 || out_sel !== 4'd7 || out_data !== 8'h77) begin
        failures++; $display("FAIL drain_idle[%0d] got=%0b/%0d/%h exp=0/7/77", k, out_valid, out_sel, out_data); end
    end
  endtask

  task automatic test_toggle_ready();
    // Lanes 2 and 9 requesting, out_ready toggling each cycle.
    do_reset();
    in_valid = 16'h0204; in_data[2*8 +: 8] = 8'h22; in_data[9*8 +: 8] = 8'h99; out_ready = 1'b0;
    step();
    checks++; if (out_sel !== 4'd2) begin failures++; $display("FAIL toggle_0 got=%0d exp=2", out_sel); end
    step();
    checks++; if (out_sel !== 4'd2 || out_valid !== 1'b1) begin failures++; $display("FAIL toggle_hold got=%0d/%0b exp=2/1", out_sel, out_valid); end
    out_ready = 1'b1;
    step();
    checks++; if (out_sel !== 4'd9 || out_data !== 8'h99) begin failures++; $display("FAIL toggle_1 got=%0d/%h exp=9/99", out_sel, out_data); end
    out_ready = 1'b0;
    step();
    checks++; if (out_sel !== 4'd9) begin failures++; $display("FAIL toggle_hold2 got=%0d exp=9", out_sel); end
    out_ready = 1'b1;
    step();
    checks++; if (out_sel !== 4'd2) begin failures++; $display("FAIL toggle_2 got=%0d exp=2", out_sel); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_data = '0; in_valid = '0; out_ready = 1'b0;
    in_data5 = '0; in_valid5 = '0; out_ready5 = 1'b0;
    test_reset();
    test_all_lanes();
    test_sparse();
    test_backpressure();
    test_wrap_n5();
    test_idle_drain();
    test_toggle_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
